mips_fetch_stage: RTL and testbench

Instruction-fetch stage with IF/ID pipeline register, directly upstream of the main Control decoder. Holds the PC, addresses instruction memory, and latches each fetched word into IF/ID. Exports the opcode field (ifid_instr[31:26]) straight to Control. Applies branch and jump redirects, pipeline stalls and flushes, and keeps a count of delivered instructions.

---
 rtl/mips_fetch_stage.sv | 61 ++++++
 tb/tb_mips_fetch_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_stage.sv
// mips_fetch_stage: PC register, instruction fetch and IF/ID latch with redirect, stall, flush and delivery count.
module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             stall,
  input  logic             flush,
  input  logic             branch_taken,
  input  logic [15:0]      branch_offset,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  output logic [31:0]      pc,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc4,
  output logic             ifid_valid,
  output logic [5:0]       op,
  output logic [CNT_W-1:0] fetch_count
);
  logic [31:0] pcPlus4, brTarget, jTarget;
  logic doJump, doBranch;
  assign pcPlus4   = pc + 32'd4;
  assign brTarget  = ifid_pc4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign jTarget   = {ifid_pc4[31:28], jump_index, 2'b00};
  assign doJump    = jump & ifid_valid;
  assign doBranch  = branch_taken & ifid_valid;
  assign imem_addr = pc;
  assign op        = ifid_instr[31:26];
  // Redirects resolve the instruction already in IF/ID, so they beat stall and flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      ifid_instr  <= '0;
      ifid_pc4    <= '0;
      ifid_valid  <= 1'b0;
      fetch_count <= '0;
    end else if (doJump || doBranch) begin
      pc         <= doJump ? jTarget : brTarget;
      ifid_instr <= '0;
      ifid_valid <= 1'b0;
    end else if (stall) begin
      if (flush) begin
        ifid_instr <= '0;
        ifid_valid <= 1'b0;
      end
    end else if (flush) begin
      pc         <= pcPlus4;
      ifid_instr <= '0;
      ifid_valid <= 1'b0;
    end else begin
      pc         <= pcPlus4;
      ifid_instr <= imem_rdata;
      ifid_pc4   <= pcPlus4;
      ifid_valid <= 1'b1;
      if (fetch_count != '1) fetch_count <= fetch_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_mips_fetch_stage.sv
// tb_mips_fetch_stage: vector table, hand sequences and randomized run against a behavioural fetch model.
module tb_mips_fetch_stage;
  logic clk = 0, rst_n = 0;
  logic stall = 0, flush = 0, branch_taken = 0, jump = 0;
  logic [15:0] branch_offset = '0;
  logic [25:0] jump_index = '0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] imem_addr, pc, ifid_instr, ifid_pc4;
  logic [31:0] imem_addr4, pcB, ifid_instrB, ifid_pc4B;
  logic ifid_valid, ifid_validB;
  logic [5:0] op, opB;
  logic [15:0] cnt16;
  logic [3:0] cnt4;
  int tests = 0, fails = 0;
  logic [31:0] mPc, mInstr, mPc4;
  logic mValid;
  int mCnt;

  mips_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .flush(flush), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_index(jump_index), .pc(pc), .ifid_instr(ifid_instr),
    .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid), .op(op), .fetch_count(cnt16)
  );
  mips_fetch_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr4), .imem_rdata(imem_rdata),
    .stall(stall), .flush(flush), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_index(jump_index), .pc(pcB), .ifid_instr(ifid_instrB),
    .ifid_pc4(ifid_pc4B), .ifid_valid(ifid_validB), .op(opB), .fetch_count(cnt4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mPc = 32'h0; mInstr = 32'h0; mPc4 = 32'h0; mValid = 0; mCnt = 0;
  endtask

  // One edge of the fetch rules, expressed with plain address arithmetic.
  task automatic modelEdge();
    int off;
    off = int'($signed(branch_offset)) * 4;
    if (mValid && jump) begin
      mPc = (mPc4 & 32'hF000_0000) + jump_index * 4;
      mInstr = 0; mValid = 0;
    end else if (mValid && branch_taken) begin
      mPc = mPc4 + 32'(off);
      mInstr = 0; mValid = 0;
    end else if (stall) begin
      if (flush) begin mInstr = 0; mValid = 0; end
    end else if (flush) begin
      mPc = mPc + 4;
      mInstr = 0; mValid = 0;
    end else begin
      mInstr = imem_rdata; mPc = mPc + 4; mPc4 = mPc; mValid = 1; mCnt++;
    end
  endtask

  task automatic compareAll(input string tag);
    check({tag, " pc"}, pc, mPc);
    check({tag, " imem_addr"}, imem_addr, mPc);
    check({tag, " ifid_instr"}, ifid_instr, mInstr);
    check({tag, " ifid_pc4"}, ifid_pc4, mPc4);
    check({tag, " ifid_valid"}, 32'(ifid_valid), 32'(mValid));
    check({tag, " op"}, 32'(op), 32'(mInstr[31:26]));
    check({tag, " count16"}, 32'(cnt16), 32'(mCnt > 65535 ? 65535 : mCnt));
    check({tag, " count4"}, 32'(cnt4), 32'(mCnt > 15 ? 15 : mCnt));
    check({tag, " cnt4 pc"}, pcB, mPc);
  endtask

  task automatic step(input string tag);
    modelEdge();
    @(posedge clk);
    #1;
    compareAll(tag);
  endtask

  task automatic drive(input logic s, input logic f, input logic b, input logic [15:0] o,
                       input logic j, input logic [25:0] ji, input logic [31:0] rd);
    stall = s; flush = f; branch_taken = b; branch_offset = o; jump = j; jump_index = ji; imem_rdata = rd;
  endtask

  typedef struct {
    logic s, f, b;
    logic [15:0] o;
    logic j;
    logic [25:0] ji;
    logic [31:0] rd, ePc;
    logic [5:0] eOp;
    logic eValid;
    logic [31:0] ePc4;
  } vec_t;
  vec_t vecs[17];

  initial begin
    vecs[0]  = '{0, 0, 0, 16'h0,    0, 26'h0,  32'h8C08_0004, 32'h0000_0004, 6'h23, 1, 32'h0000_0004};
    vecs[1]  = '{0, 0, 0, 16'h0,    0, 26'h0,  32'h0000_0000, 32'h0000_0008, 6'h00, 1, 32'h0000_0008};
    vecs[2]  = '{0, 0, 0, 16'h0,    0, 26'h0,  32'hAC08_0008, 32'h0000_000C, 6'h2B, 1, 32'h0000_000C};
    vecs[3]  = '{0, 0, 0, 16'h0,    0, 26'h0,  32'h1000_FFFE, 32'h0000_0010, 6'h04, 1, 32'h0000_0010};
    vecs[4]  = '{0, 0, 1, 16'hFFFE, 0, 26'h0,  32'h0800_0040, 32'h0000_0008, 6'h00, 0, 32'h0000_0010};
    vecs[5]  = '{0, 0, 0, 16'h0,    0, 26'h0,  32'h0800_0040, 32'h0000_000C, 6'h02, 1, 32'h0000_000C};
    vecs[6]  = '{1, 1, 1, 16'h0007, 1, 26'h40, 32'h1234_5678, 32'h0000_0100, 6'h00, 0, 32'h0000_000C};
    vecs[7]  = '{0, 0, 0, 16'h0,    0, 26'h0,  32'h2402_0005, 32'h0000_0104, 6'h09, 1, 32'h0000_0104};
    vecs[8]  = '{1, 0, 0, 16'h0,    0, 26'h0,  32'hFFFF_FFFF, 32'h0000_0104, 6'h09, 1, 32'h0000_0104};
    vecs[9]  = '{1, 0, 0, 16'h0,    0, 26'h0,  32'h8C00_0000, 32'h0000_0104, 6'h09, 1, 32'h0000_0104};
    vecs[10] = '{1, 0, 0, 16'h0,    0, 26'h0,  32'h0800_0001, 32'h0000_0104, 6'h09, 1, 32'h0000_0104};
    vecs[11] = '{1, 1, 0, 16'h0,    0, 26'h0,  32'h0800_0001, 32'h0000_0104, 6'h00, 0, 32'h0000_0104};
    vecs[12] = '{0, 0, 1, 16'h0100, 1, 26'h3FF, 32'h8C09_0000, 32'h0000_0108, 6'h23, 1, 32'h0000_0108};
    vecs[13] = '{0, 1, 0, 16'h0,    0, 26'h0,  32'hAC00_0000, 32'h0000_010C, 6'h00, 0, 32'h0000_0108};
    vecs[14] = '{0, 0, 1, 16'h0020, 0, 26'h0,  32'h0800_0000, 32'h0000_0110, 6'h02, 1, 32'h0000_0110};
    vecs[15] = '{0, 0, 1, 16'hFFBB, 0, 26'h0,  32'h0000_0000, 32'hFFFF_FFFC, 6'h00, 0, 32'h0000_0110};
    vecs[16] = '{0, 0, 0, 16'h0,    0, 26'h0,  32'h3C01_1234, 32'h0000_0000, 6'h0F, 1, 32'h0000_0000};
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    compareAll("in_reset");
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].s, vecs[i].f, vecs[i].b, vecs[i].o, vecs[i].j, vecs[i].ji, vecs[i].rd);
      step($sformatf("vec%0d", i));
      check($sformatf("vec%0d exp_pc", i), pc, vecs[i].ePc);
      check($sformatf("vec%0d exp_op", i), 32'(op), 32'(vecs[i].eOp));
      check($sformatf("vec%0d exp_valid", i), 32'(ifid_valid), 32'(vecs[i].eValid));
      check($sformatf("vec%0d exp_pc4", i), ifid_pc4, vecs[i].ePc4);
    end
    check("table count16", 32'(cnt16), 32'd9);
    check("table count4", 32'(cnt4), 32'd9);
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 16'h0, 0, 26'h0, $urandom);
      step($sformatf("sat%0d", i));
    end
    check("saturated count4", 32'(cnt4), 32'hF);
    check("count16 after 29", 32'(cnt16), 32'd29);
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            16'($urandom), $urandom_range(0, 7) == 0, 26'($urandom), $urandom);
      step($sformatf("rnd%0d", i));
    end
    drive(0, 0, 0, 16'h0, 0, 26'h0, 32'h8C08_0004);
    #3;
    rst_n = 0;
    #1;
    modelReset();
    check("async pc", pc, 32'h0);
    check("async valid", 32'(ifid_valid), 32'h0);
    check("async op", 32'(op), 32'h0);
    check("async count", 32'(cnt16), 32'h0);
    @(negedge clk);
    rst_n = 1;
    step("post_reset");
    check("post ifid_instr", ifid_instr, 32'h8C08_0004);
    check("post op", 32'(op), 32'h23);
    check("post ifid_pc4", ifid_pc4, 32'h4);
    check("post pc", pc, 32'h4);
    check("post count", 32'(cnt16), 32'h1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
